bcd2bin: RTL
============

// Module: bcd2bin
// PURPOSE
//  Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from every digit >= 8.
//  It is the decode direction of the binary-to-BCD path in the LED driver.
//  It takes a 6-digit packed BCD word (for example a keypad or preset value) and returns the 20-bit binary count.
//  Uses a start/busy/done handshake. One result per 21-cycle conversion.
// PARAMETERS
//  DIGITS  6   number of packed BCD digits; input width = 4*DIGITS
//  BW      20  binary result width; must satisfy 10^DIGITS-1 < 2^BW
// PORTS
//  clk    in   1   single system clock, rising edge
//  rstn   in   1   asynchronous active-low reset
//  start  in   1   request; sampled only while idle (busy=0)
//  dcm    in   24  packed BCD, dcm[23:20] = most significant digit
//  busy   out  1   high from the cycle after start is accepted until done rises
//  done   out  1   one-cycle pulse; bny and err are valid from this cycle
//  bny    out  20  binary result, held until the next done
//  err    out  1   input contained a nibble > 9; held until the next done
// BEHAVIOUR
//  - Reset (async, rstn=0): state IDLE; all outputs 0; shift register and counter 0.
//    Reset mid-conversion aborts the conversion, and no done is issued.
//  - Shift register sr is 44 bits, arranged as {bcd[23:0], bin[19:0]}. Iteration counter cnt is 5 bits.
//  - States:
//    - IDLE: start=1 at edge E0.
//      - If all nibbles are <= 9: sr <= {dcm, 20'b0}, cnt <= 0, busy <= 1, go to CONV.
//      - If any nibble is > 9: go to ERR; busy <= 1.
//    - CONV: one iteration per edge. First t = sr >> 1. Then each of the 6 BCD nibbles of t: if >= 8, subtract 3. sr <= t; cnt++.
//      - On the edge where cnt == BW-1 (E20): bny <= final sr[19:0], err <= 0, done <= 1, busy <= 0, go to IDLE.
//    - ERR: at E1: bny <= 0, err <= 1, done <= 1, busy <= 0, go to IDLE.
//  - Latency:
//    - Valid input: done is high in the cycle after the 20th edge following E0.
//    - Invalid input: done is high in the cycle after E1.
//  - start while busy=1 is ignored; it is not queued.
//    start held high continuously re-triggers back-to-back. The cycle in which done=1 is already IDLE, so start in that cycle is accepted.
//  - dcm is sampled only at E0; later changes do not affect the running conversion.
//  - done defaults to 0 on every edge it is not explicitly set.
//    bny and err change only on the edge that sets done.
//  - Arithmetic: the nibble correction is 4-bit unsigned; a nibble >= 8 never underflows.
//    Result range is 0..999999 (0x00000..0xF423F), with no overflow given BW=20.
// STRUCTURE
//  - Shared package led_pkg:
//    - constants BCD_DIGITS=6, BIN_W=20, BCD_W=24;
//    - localparam state encoding IDLE=2'd0, CONV=2'd1, ERR=2'd2.
//  - Sub-module bcd_nib_adj (combinational): 4-bit in, 4-bit out = (in >= 8) ? in-3 : in. Instantiated 6 times via generate.
//  - Top holds the FSM, the 5-bit cnt, sr, the validity check, and the output registers.
// TESTING
//  1. dcm=24'h999999, start 1 cycle -> busy for 20 cycles, done pulse, bny=20'hF423F, err=0.
//  2. dcm=24'h123456 -> bny=20'h1E240. Then dcm=24'h000000 -> bny=0. done pulses exactly once each.
//  3. dcm=24'h00A000 -> done in the cycle after E1, err=1, bny=0. The next valid request 24'h000001 clears err and gives bny=1.
//  4. Pulse start again 5 cycles into a conversion (with a different dcm) -> ignored; the result matches the first dcm only.
//  5. Deassert rstn at iteration 10, release, start dcm=24'h000042 -> no done during the abort; then bny=20'h0002A.
//  6. Round trip: drive random 0..999999 through the bcd module, then this block -> bny equals the original value over 1000 samples.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED driver BCD/binary conversion paths.
//   BCD_DIGITS : number of packed BCD digits handled by the converters
//   BIN_W      : binary count width (holds 0..999999)
//   BCD_W      : packed BCD word width
//   IDLE/CONV/ERR : state encoding of the BCD-to-binary sequencer
package led_pkg;

    localparam int BCD_DIGITS = 6;
    localparam int BIN_W      = 20;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

endpackage

// File: rtl/bcd_nib_adj.sv
// Per-digit correction step of reverse double dabble.
// After a right shift, a digit that received the carry-in from the digit
// above reads 8 or more; removing 3 restores its decimal weight (16/2 = 8
// versus 10/2 = 5).
//   nib_in  : 4-bit digit after the shift
//   nib_out : corrected digit
module bcd_nib_adj (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // Inputs >= 8 are at least 8, so the 4-bit subtraction never wraps.
    assign nib_out = (nib_in >= 4'd8) ? (nib_in - 4'd3) : nib_in;

endmodule

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// A 20-iteration shift/correct loop turns a 6-digit BCD word into its binary
// count; words containing a nibble above 9 are rejected with err.
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   start : conversion request, honoured only while idle
//   dcm   : packed BCD input, dcm[23:20] = most significant digit
//   busy  : conversion in progress
//   done  : one-cycle pulse, bny/err valid from this cycle
//   bny   : binary result, held until the next done
//   err   : input had a non-decimal nibble, held until the next done
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; validates and loads dcm
// CONV  | one shift/correct iteration per cycle, BW iterations total
// ERR   | invalid input seen; report err on the next edge
module bcd2bin
    import led_pkg::*;
#(
    parameter int DIGITS = BCD_DIGITS,
    parameter int BW     = BIN_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [4*DIGITS-1:0] dcm,
    output logic                busy,
    output logic                done,
    output logic [BW-1:0]       bny,
    output logic                err
);

    localparam int         DW       = 4 * DIGITS;
    localparam int         SW       = DW + BW;
    localparam logic [4:0] CNT_LAST = 5'(BW - 1);

    logic [1:0]    state;
    logic [SW-1:0] sr;
    logic [4:0]    cnt;

    logic [SW-1:0] sr_shift;
    logic [DW-1:0] bcd_adj;
    logic [SW-1:0] sr_next;
    logic          dcm_ok;

    // sr = {bcd digits, binary}; bits shift out of the BCD field into the
    // binary field, then every digit is corrected.
    assign sr_shift = sr >> 1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_nib_adj u_adj (
            .nib_in  (sr_shift[BW + 4*i +: 4]),
            .nib_out (bcd_adj[4*i +: 4])
        );
    end

    assign sr_next = {bcd_adj, sr_shift[BW-1:0]};

    always_comb begin
        dcm_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dcm[4*i +: 4] > 4'd9) dcm_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bny   <= '0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (dcm_ok) begin
                            sr    <= {dcm, {BW{1'b0}}};
                            cnt   <= '0;
                            state <= CONV;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                CONV: begin
                    sr  <= sr_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        bny   <= sr_next[BW-1:0];
                        err   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    bny   <= '0;
                    err   <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
